// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a fixed-latency ROM interface,
// an in-flight tracking pipe and a DEPTH-entry output FIFO feeding ID over a
// valid/ready handshake. Branch/jump redirects flush all fetched work.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a matching ROM
// return that finds the FIFO empty is shown on id_* in the same cycle.
module if_fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter int                ROM_LAT  = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_ce_o,
   input  logic [INST_W-1:0] rom_data_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   input  logic              id_ready_i,
   output logic              id_valid_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic               epoch_q, epoch_d;

   // In-flight pipe: slot 0 is the newest request, slot ROM_LAT-1 pairs with rom_data_i.
   logic [ROM_LAT-1:0] fl_vld_q;
   logic [ROM_LAT-1:0] fl_ep_q;
   logic [ADDR_W-1:0]  fl_pc_q [ROM_LAT];

   logic [ADDR_W-1:0]  fifo_pc_q   [DEPTH];
   logic [INST_W-1:0]  fifo_inst_q [DEPTH];

   logic [CNT_W-1:0]   inflight;
   logic [CNT_W:0]     credit_used;
   logic               issue;
   logic               ret_vld;
   logic [ADDR_W-1:0]  ret_pc;
   logic               fifo_vld;
   logic               push;
   logic               pop;

   // Count outstanding ROM requests and decide whether a new one may issue.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      inflight = '0;
      for (int i = 0; i < ROM_LAT; i++) begin
         inflight = inflight + CNT_W'(fl_vld_q[i]);
      end
      credit_used = {1'b0, count_q} + {1'b0, inflight};
      issue       = !rst && !flush_i && (credit_used < (CNT_W + 1)'(DEPTH));
   end

   assign rom_ce_o   = issue;
   assign rom_addr_o = pc_q;
   assign ret_vld    = fl_vld_q[ROM_LAT-1] && (fl_ep_q[ROM_LAT-1] == epoch_q);
   assign ret_pc     = fl_pc_q[ROM_LAT-1];
   assign fifo_vld   = !rst && (count_q != '0);

`ifdef FETCH_BYPASS_EN
   logic bypass_hit;

   // Present the FIFO head, or a fresh return straight through when the FIFO is empty.
   always_comb begin
      bypass_hit = !rst && (count_q == '0) && ret_vld;
      id_valid_o = fifo_vld || bypass_hit;
      id_pc_o    = '0;
      id_inst_o  = '0;
      if (fifo_vld) begin
         id_pc_o   = fifo_pc_q[rd_ptr_q];
         id_inst_o = fifo_inst_q[rd_ptr_q];
      end else if (bypass_hit) begin
         id_pc_o   = ret_pc;
         id_inst_o = rom_data_i;
      end
      push = ret_vld && !(bypass_hit && id_ready_i);
      pop  = fifo_vld && id_ready_i && !flush_i;
   end
`else
   // Present the FIFO head only; id_* never depend combinationally on rom_data_i.
   always_comb begin
      id_valid_o = fifo_vld;
      id_pc_o    = fifo_vld ? fifo_pc_q[rd_ptr_q]   : '0;
      id_inst_o  = fifo_vld ? fifo_inst_q[rd_ptr_q] : '0;
      push       = ret_vld;
      pop        = fifo_vld && id_ready_i && !flush_i;
   end
`endif

   // Next-state for PC, FIFO occupancy/pointers and epoch; a redirect overrides all.
   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      epoch_d  = epoch_q;
      if (flush_i) begin
         pc_d     = flush_pc_i;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         epoch_d  = ~epoch_q;
      end else begin
         if (issue) pc_d     = pc_q + ADDR_W'(4);
         if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state: synchronous reset wins over a simultaneous flush.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (rst) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         epoch_q  <= 1'b0;
         fl_vld_q <= '0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         epoch_q  <= epoch_d;
         // Clearing in-flight valids on a redirect backs up the epoch check, which alone
         // could alias after two flushes inside one ROM latency window.
         if (flush_i) begin
            fl_vld_q <= '0;
         end else begin
            for (int i = ROM_LAT - 1; i > 0; i--) fl_vld_q[i] <= fl_vld_q[i-1];
            fl_vld_q[0] <= issue;
         end
      end
   end

   // Payload storage: in-flight tags and FIFO entries, qualified by the valid state above.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays carry no reset; their valid bits and count are reset instead.
      for (int i = ROM_LAT - 1; i > 0; i--) begin
         fl_pc_q[i] <= fl_pc_q[i-1];
         fl_ep_q[i] <= fl_ep_q[i-1];
      end
      fl_pc_q[0] <= pc_q;
      fl_ep_q[0] <= epoch_q;
      if (push && !flush_i) begin
         fifo_pc_q[wr_ptr_q]   <= ret_pc;
         fifo_inst_q[wr_ptr_q] <= rom_data_i;
      end
   end

   // The credit rule makes these unreachable; they guard future edits.
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !(pop && (count_q == '0)));
   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: scoreboard bench for if_fetch_queue. A delay-line ROM
// returns a scrambled function of each address; every issue pushes the
// expected {pc, inst, issue cycle} and each handshake pops and compares.
module tb_if_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          ROM_LAT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
   localparam int          LAT      = ROM_LAT;
`else
   localparam int          LAT      = ROM_LAT + 1;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      int          t;
   } ent_t;

   logic        clk;
   logic        rst;
   logic [31:0] rom_addr_o;
   logic        rom_ce_o;
   logic [31:0] rom_data_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        id_ready_i;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;

   ent_t        sb [$];
   logic [31:0] mdl_pc;
   logic [31:0] rom_pipe [ROM_LAT];
   int          cyc;
   int          n_checks;
   int          n_errs;
   int          n_dut_pop;
   logic [31:0] last_dut_pc;
   logic [31:0] first_pop_pc;
   bit          await_first;
   bit          saw_wrap;

   if_fetch_queue #(
      .ADDR_W  (32),
      .INST_W  (32),
      .DEPTH   (DEPTH),
      .ROM_LAT (ROM_LAT),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rom_addr_o(rom_addr_o),
      .rom_ce_o  (rom_ce_o),
      .rom_data_i(rom_data_i),
      .flush_i   (flush_i),
      .flush_pc_i(flush_pc_i),
      .id_ready_i(id_ready_i),
      .id_valid_o(id_valid_o),
      .id_pc_o   (id_pc_o),
      .id_inst_o (id_inst_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // Fixed-latency ROM: data for the address seen at an edge appears ROM_LAT cycles later.
   always @(posedge clk) begin
      rom_pipe[0] <= rom_addr_o;
      for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data_i = rom_f(rom_pipe[ROM_LAT-1]);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s actual=%h expected=%h cycle=%0d", tag, act, exp, cyc);
      end
   endtask

   // Compare this cycle's outputs with the model, then advance the model past the edge.
   task automatic monitor();
      bit   exp_ce;
      bit   exp_vld;
      ent_t e;
      exp_ce  = !rst && !flush_i && (sb.size() < DEPTH);
      exp_vld = !rst && (sb.size() > 0) && ((cyc - sb[0].t) >= LAT);
      check("rom_ce", {31'b0, rom_ce_o}, {31'b0, exp_ce});
      check("id_valid", {31'b0, id_valid_o}, {31'b0, exp_vld});
      if (exp_vld) begin
         check("id_pc", id_pc_o, sb[0].pc);
         check("id_inst", id_inst_o, sb[0].inst);
      end else begin
         check("id_pc_zero", id_pc_o, 32'h0);
         check("id_inst_zero", id_inst_o, 32'h0);
      end
      if (!rst && !flush_i && id_valid_o && id_ready_i) begin
         n_dut_pop++;
         if (id_pc_o == 32'h0 && last_dut_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
         last_dut_pc = id_pc_o;
         if (await_first) begin
            first_pop_pc = id_pc_o;
            await_first  = 1'b0;
         end
      end
      if (rst) begin
         sb.delete();
         mdl_pc      = RESET_PC;
         await_first = 1'b1;
      end else if (flush_i) begin
         sb.delete();
         mdl_pc      = flush_pc_i;
         await_first = 1'b1;
      end else begin
         if (exp_ce) begin
            check("rom_addr", rom_addr_o, mdl_pc);
            sb.push_back('{pc: mdl_pc, inst: rom_f(mdl_pc), t: cyc});
            mdl_pc = mdl_pc + 32'd4;
         end
         if (exp_vld && id_ready_i) e = sb.pop_front();
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample, wait for the next one.
   task automatic tick(input logic r, input logic f, input logic [31:0] fpc, input logic rdy);
      rst        = r;
      flush_i    = f;
      flush_pc_i = fpc;
      id_ready_i = rdy;
      #1;
      monitor();
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      int p0;
      rst         = 1'b1;
      flush_i     = 1'b0;
      flush_pc_i  = 32'h0;
      id_ready_i  = 1'b0;
      mdl_pc      = RESET_PC;
      cyc         = 0;
      n_checks    = 0;
      n_errs      = 0;
      n_dut_pop   = 0;
      last_dut_pc = 32'h0;
      first_pop_pc = 32'hDEAD_BEEF;
      await_first = 1'b1;
      saw_wrap    = 1'b0;
      @(negedge clk);

      // Reset, then release with ID always ready: sustained one per cycle.
      repeat (3) tick(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (5) tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("t1_first", first_pop_pc, RESET_PC);
      p0 = n_dut_pop;
      repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("t1_thruput", 32'(n_dut_pop - p0), 32'd8);

      // ID stalls: the queue fills to DEPTH and fetch stops, nothing lost.
      repeat (10) tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("t2_ce_low", {31'b0, rom_ce_o}, 32'h0);
      check("t2_vld_held", {31'b0, id_valid_o}, 32'h1);
      repeat (6) tick(1'b0, 1'b0, 32'h0, 1'b1);

      // Redirect with returns in flight: stale ones vanish, target comes next.
      tick(1'b0, 1'b1, 32'h100, 1'b1);
      repeat (6) tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("t3_first", first_pop_pc, 32'h100);

      // Full queue with ID ready toggling: push and pop together keep it full.
      repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 32'h0, logic'(i % 2 == 0));

      // Reset mid-stream together with a flush: reset wins, fetch restarts at RESET_PC.
      repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0);
      tick(1'b1, 1'b1, 32'h200, 1'b0);
      repeat (6) tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("t5_restart", first_pop_pc, RESET_PC);

      // PC wrap at the top of the address space.
      tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      repeat (8) tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("t6_first", first_pop_pc, 32'hFFFF_FFFC);
      check("t6_wrap", {31'b0, saw_wrap}, 32'h1);

      // Mixed traffic: random stalls, redirects and occasional resets.
      for (int i = 0; i < 300; i++) begin
         tick(logic'($urandom_range(0, 99) == 0),
              logic'($urandom_range(0, 24) == 0),
              32'($urandom()),
              logic'($urandom_range(0, 3) != 0));
      end
      repeat (10) tick(1'b0, 1'b0, 32'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
